uart_block_packer: RTL and testbench
====================================

// Module: uart_block_packer
// PURPOSE
//  Packs bytes from uart_rx (o_data/o_data_valid) into one 128-bit AES block and presents it to
//  the AES core with a valid/ready handshake. Sits between uart_rx and the AES datapath.
//  Double-buffered: a block awaiting acceptance does not stall assembly of the next one.
//  Stale partial blocks are discarded after an inter-byte timeout.
// PARAMETERS
//  N_DATA_BITS     8          width of one UART character
//  N_BYTES         16         characters per block; block width is N_BYTES*N_DATA_BITS
//  TIMEOUT_CYCLES  1_000_000  idle i_clk cycles before a partial block is discarded; 0 = disabled
// PORTS
//  i_clk           in   1        single clock for all logic
//  i_reset_n       in   1        asynchronous, active-low reset
//  i_byte          in   N_DATA_BITS          received character from uart_rx
//  i_byte_valid    in   1        uart_rx valid, a level held for >=1 cycle
//  i_flush         in   1        sync clear of partial assembly and of any pending block
//  o_block         out  N_BYTES*N_DATA_BITS  assembled block; byte k in bits [8k+7:8k]
//  o_block_valid   out  1        o_block is valid
//  i_block_ready   in   1        consumer accepts o_block when o_block_valid && i_block_ready
//  o_byte_count    out  $clog2(N_BYTES)+1     bytes in the current partial assembly, 0..N_BYTES
//  o_overrun       out  1        sticky; a byte was dropped because both buffers were full
//  o_timeout       out  1        one-cycle pulse when a partial block is discarded on timeout
// BEHAVIOUR
//  Reset (async assert, sync deassert by the upstream synchroniser): all outputs, counters and
//   buffers are 0 and the state is COLLECT.
//  Byte capture: only the rising edge of i_byte_valid (registered compare) accepts a byte, so a
//   held level is taken once. The accepted byte is written to slot o_byte_count, which then increments.
//  States:
//   COLLECT: accept bytes. When the N_BYTES-th byte is accepted, the assembly moves to the output
//    register on the next edge if the output is empty or is being accepted that same cycle;
//    o_byte_count returns to 0 and the state stays COLLECT. Otherwise go to PENDING.
//   PENDING: the full assembly is held. Any byte edge is dropped and sets o_overrun.
//    When the output register frees (valid && ready), transfer the assembly the same edge,
//    clear o_byte_count and return to COLLECT.
//  Output register: o_block_valid rises the cycle after transfer. o_block stays stable while
//   valid && !ready. valid clears on acceptance unless a new transfer lands on the same edge,
//   in which case valid stays 1 and o_block updates.
//  Latency: last byte edge to o_block_valid is 2 cycles (edge register, then transfer).
//  Timeout: an idle counter resets on every accepted byte and runs only in COLLECT with
//   0 < o_byte_count < N_BYTES. When it reaches TIMEOUT_CYCLES-1: o_byte_count becomes 0 and
//   o_timeout pulses. The output register is untouched.
//  i_flush: has priority over byte capture and timeout. It clears the assembly, o_byte_count,
//   PENDING and the idle counter. It does not clear o_block_valid (a block already presented
//   completes its handshake). It does not clear o_overrun; only reset clears o_overrun.
//  Simultaneous byte edge and timeout expiry: the byte wins. It is captured and the counter restarts.
//  o_byte_count wraps N_BYTES-1 -> 0 only through the transfer path and never reads N_BYTES in
//   COLLECT. It reads N_BYTES only in PENDING.
// STRUCTURE
//  aes_uart_pkg: AES_BLOCK_BYTES=16, AES_BLOCK_W=128, typedef logic [127:0] aes_block_t,
//   and the packer_state_e enum {COLLECT, PENDING}.
//  One sub-module, idle_timeout_counter (params WIDTH, LIMIT; ports i_clk, i_reset_n, i_clear,
//   i_run, o_expired), shared with the future TX-side watchdog. All other logic stays inline.
// TESTING
//  1 Send bytes 0x00..0x0F with ready=1 -> o_block_valid high 2 cycles after the last edge,
//    o_block=128'h0F0E..0100, a one-cycle valid, count back to 0.
//  2 Hold i_byte_valid high for 20 cycles with 0xA5 -> exactly one byte captured, o_byte_count=1.
//  3 ready=0: send 32 bytes (block A 0x00..0x0F, block B 0x10..0x1F) -> A presented and stable,
//    state PENDING. A 33rd byte sets o_overrun. Raise ready -> A accepted, then B presented.
//  4 TIMEOUT_CYCLES=100: send 5 bytes, then idle -> o_timeout pulses 100 cycles after the 5th
//    byte and count=0. Then 16 fresh bytes -> a correct block.
//  5 Assert i_flush after 7 bytes while a block is presented -> count=0, o_block_valid stays 1
//    and o_block is unchanged.
//  6 Assert i_reset_n low mid-block (count=9, valid=1) -> all outputs 0 immediately, without a
//    clock. After release, a 16-byte sequence packs correctly.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the UART-to-AES receive path.
package aes_uart_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_BLOCK_W     = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } packer_state_e;

endpackage

// File: rtl/idle_timeout_counter.sv
// Counts run cycles since the last clear; o_expired flags the LIMIT-1 count. LIMIT=0 disables it.
module idle_timeout_counter #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned LIMIT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    logic [WIDTH-1:0] cnt_q;

    assign o_expired = (LIMIT != 0) && i_run && (cnt_q == WIDTH'(LIMIT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_run && !o_expired && (LIMIT != 0)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_block_packer.sv
// Packs UART characters into a block with a double-buffered valid/ready output, idle timeout
// discard of partial blocks, and a sticky overrun flag.
module uart_block_packer
    import aes_uart_pkg::*;
#(
    parameter int unsigned N_DATA_BITS    = 8,
    parameter int unsigned N_BYTES        = AES_BLOCK_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [N_DATA_BITS-1:0]           i_byte,
    input  logic                             i_byte_valid,
    input  logic                             i_flush,
    output logic [N_BYTES*N_DATA_BITS-1:0]   o_block,
    output logic                             o_block_valid,
    input  logic                             i_block_ready,
    output logic [$clog2(N_BYTES):0]         o_byte_count,
    output logic                             o_overrun,
    output logic                             o_timeout
);

    localparam int unsigned BW = N_BYTES * N_DATA_BITS;
    localparam int unsigned CW = $clog2(N_BYTES) + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);
    localparam logic [CW-1:0] FULL = CW'(N_BYTES);

    packer_state_e           state_q;
    logic                    valid_prev_q;
    logic                    edge_q;
    logic [N_DATA_BITS-1:0]  byte_q;
    logic [BW-1:0]           asm_q;

    logic          accept, capture, drop, out_free;
    logic          xfer_collect, xfer_pending;
    logic          idle_run, idle_clear, idle_expired;
    logic [BW-1:0] asm_wr;

    always_comb begin
        accept       = o_block_valid & i_block_ready;
        out_free     = ~o_block_valid | i_block_ready;
        capture      = edge_q & ~i_flush & (state_q == COLLECT);
        drop         = edge_q & ~i_flush & (state_q == PENDING);
        xfer_collect = capture & (o_byte_count == LAST) & out_free;
        xfer_pending = ~i_flush & (state_q == PENDING) & accept;
        idle_run     = (state_q == COLLECT) && (o_byte_count != '0) && (o_byte_count < FULL);
        idle_clear   = i_flush | capture | ~idle_run;
        asm_wr       = asm_q;
        for (int k = 0; k < N_BYTES; k++) begin
            if (o_byte_count == CW'(k)) begin
                asm_wr[k*N_DATA_BITS +: N_DATA_BITS] = byte_q;
            end
        end
    end

    idle_timeout_counter #(
        .WIDTH (TW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (idle_clear),
        .i_run     (idle_run),
        .o_expired (idle_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= COLLECT;
            valid_prev_q  <= 1'b0;
            edge_q        <= 1'b0;
            byte_q        <= '0;
            asm_q         <= '0;
            o_block       <= '0;
            o_block_valid <= 1'b0;
            o_byte_count  <= '0;
            o_overrun     <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            valid_prev_q <= i_byte_valid;
            edge_q       <= i_byte_valid & ~valid_prev_q;
            byte_q       <= i_byte;
            o_timeout    <= 1'b0;

            if (drop) begin
                o_overrun <= 1'b1;
            end

            // A transfer landing on an acceptance edge keeps valid high with the new block.
            if (xfer_collect || xfer_pending) begin
                o_block       <= xfer_collect ? asm_wr : asm_q;
                o_block_valid <= 1'b1;
            end else if (accept) begin
                o_block_valid <= 1'b0;
            end

            if (i_flush) begin
                asm_q        <= '0;
                o_byte_count <= '0;
                state_q      <= COLLECT;
            end else if (capture) begin
                if (o_byte_count != LAST) begin
                    asm_q        <= asm_wr;
                    o_byte_count <= o_byte_count + CW'(1);
                end else if (out_free) begin
                    o_byte_count <= '0;
                end else begin
                    asm_q        <= asm_wr;
                    o_byte_count <= FULL;
                    state_q      <= PENDING;
                end
            end else if (xfer_pending) begin
                o_byte_count <= '0;
                state_q      <= COLLECT;
            end else if (idle_expired) begin
                o_byte_count <= '0;
                o_timeout    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_block_packer.sv
// Self-checking bench for uart_block_packer: directed sequences, a vector table and a random run.
module tb_uart_block_packer;

    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic [7:0]   i_byte = '0;
    logic         i_byte_valid = 1'b0;
    logic         i_flush = 1'b0;
    logic [127:0] o_block;
    logic         o_block_valid;
    logic         i_block_ready = 1'b0;
    logic [4:0]   o_byte_count;
    logic         o_overrun;
    logic         o_timeout;

    int total = 0;
    int bad   = 0;

    uart_block_packer #(
        .N_DATA_BITS    (8),
        .N_BYTES        (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .i_flush       (i_flush),
        .o_block       (o_block),
        .o_block_valid (o_block_valid),
        .i_block_ready (i_block_ready),
        .o_byte_count  (o_byte_count),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] data;
        int         hold;
        int         exp_count;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise valid for `hold` cycles, drop it, then wait one cycle so the capture has landed.
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge i_clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        repeat (hold) @(negedge i_clk);
        i_byte_valid = 1'b0;
        @(negedge i_clk);
    endtask

    function automatic logic [127:0] mk_block(input logic [7:0] base);
        logic [127:0] blk;
        for (int k = 0; k < 16; k++) blk[k*8 +: 8] = base + 8'(k);
        return blk;
    endfunction

    task automatic send_block(input logic [7:0] base);
        for (int k = 0; k < 16; k++) send_byte(base + 8'(k), 1);
    endtask

    initial begin
        logic [127:0] tblk, blk_a, blk_b, blk_c;
        int first, pulses, cnt_at_pulse, cnt_before;

        vecs[0] = '{8'hA5, 20, 1, 1'b0};
        for (int i = 1; i < 16; i++) vecs[i] = '{8'(i * 17), (i % 3) + 1, (i + 1) % 16, (i == 15)};

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_block", o_block, 0);
        check("rst_valid", o_block_valid, 0);
        check("rst_count", o_byte_count, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_timeout", o_timeout, 0);
        i_reset_n = 1'b1;

        // 1: one block with ready high, 2-cycle latency, one-cycle valid
        i_block_ready = 1'b1;
        for (int k = 0; k < 15; k++) send_byte(8'(k), 1);
        check("t1_count15", o_byte_count, 15);
        @(negedge i_clk);
        i_byte = 8'h0F;
        i_byte_valid = 1'b1;
        @(negedge i_clk);
        check("t1_not_early", o_block_valid, 0);
        i_byte_valid = 1'b0;
        @(negedge i_clk);
        check("t1_valid", o_block_valid, 1);
        check("t1_block", o_block, 128'h0F0E0D0C0B0A09080706050403020100);
        check("t1_count0", o_byte_count, 0);
        @(negedge i_clk);
        check("t1_valid_drop", o_block_valid, 0);

        // 2: table of bytes with varied hold times; held level captured once
        for (int i = 0; i < 16; i++) begin
            send_byte(vecs[i].data, vecs[i].hold);
            tblk[i*8 +: 8] = vecs[i].data;
            check("tbl_count", o_byte_count, vecs[i].exp_count);
            check("tbl_valid", o_block_valid, vecs[i].exp_valid);
        end
        check("tbl_block", o_block, tblk);
        @(negedge i_clk);

        // 3: ready low, two blocks then an overrun byte
        i_block_ready = 1'b0;
        blk_a = mk_block(8'h00);
        blk_b = mk_block(8'h10);
        send_block(8'h00);
        check("t3_a_valid", o_block_valid, 1);
        check("t3_a_block", o_block, blk_a);
        send_block(8'h10);
        check("t3_pending_count", o_byte_count, 16);
        check("t3_a_stable", o_block, blk_a);
        check("t3_no_overrun", o_overrun, 0);
        send_byte(8'hEE, 1);
        check("t3_overrun", o_overrun, 1);
        check("t3_count_held", o_byte_count, 16);
        @(negedge i_clk);
        i_block_ready = 1'b1;
        @(negedge i_clk);
        check("t3_b_valid", o_block_valid, 1);
        check("t3_b_block", o_block, blk_b);
        check("t3_count0", o_byte_count, 0);
        @(negedge i_clk);
        check("t3_b_drained", o_block_valid, 0);

        // 4: partial block times out, then a fresh block packs correctly
        for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k), 1);
        first = -1; pulses = 0; cnt_at_pulse = -1; cnt_before = -1;
        for (int m = 1; m <= 150; m++) begin
            @(negedge i_clk);
            if (o_timeout) begin
                pulses++;
                if (first < 0) begin
                    first = m;
                    cnt_at_pulse = int'(o_byte_count);
                end
            end else if (first < 0) begin
                cnt_before = int'(o_byte_count);
            end
        end
        total++;
        if (first < 99 || first > 102) begin
            bad++;
            $display("FAIL t4_timeout_cycle: got %0d expected 99..102", first);
        end
        check("t4_pulses", pulses, 1);
        check("t4_count_at_pulse", cnt_at_pulse, 0);
        check("t4_count_before", cnt_before, 5);
        send_block(8'hC0);
        check("t4_valid", o_block_valid, 1);
        check("t4_block", o_block, mk_block(8'hC0));
        @(negedge i_clk);

        // 5: flush mid-assembly while a block is presented
        i_block_ready = 1'b0;
        blk_c = mk_block(8'h40);
        send_block(8'h40);
        for (int k = 0; k < 7; k++) send_byte(8'h90 + 8'(k), 1);
        check("t5_count7", o_byte_count, 7);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("t5_count0", o_byte_count, 0);
        check("t5_valid_kept", o_block_valid, 1);
        check("t5_block_kept", o_block, blk_c);
        i_block_ready = 1'b1;
        @(negedge i_clk);
        check("t5_drained", o_block_valid, 0);

        // 6: asynchronous reset mid-block
        i_block_ready = 1'b0;
        send_block(8'h60);
        for (int k = 0; k < 9; k++) send_byte(8'hA0 + 8'(k), 1);
        check("t6_count9", o_byte_count, 9);
        check("t6_valid", o_block_valid, 1);
        @(negedge i_clk);
        #1 i_reset_n = 1'b0;
        #1;
        check("t6_rst_block", o_block, 0);
        check("t6_rst_valid", o_block_valid, 0);
        check("t6_rst_count", o_byte_count, 0);
        check("t6_rst_overrun", o_overrun, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_block_ready = 1'b1;
        send_block(8'h80);
        check("t6_post_valid", o_block_valid, 1);
        check("t6_post_block", o_block, mk_block(8'h80));
        @(negedge i_clk);

        // Random: random bytes, gaps and ready against a block-level scoreboard
        begin
            logic [127:0] exp_q[$];
            logic [127:0] cur;
            logic [7:0]   b;
            int nb = 0, sent = 0, outstanding = 0, gap = 0, cyc = 0;
            logic timeout_seen = 1'b0;
            cur = '0;
            while ((sent < 128 || exp_q.size() > 0) && cyc < 5000) begin
                @(negedge i_clk);
                cyc++;
                timeout_seen = timeout_seen | o_timeout;
                i_block_ready = 1'($urandom_range(0, 1));
                if (o_block_valid && i_block_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected_valid", o_block_valid, 0);
                    end else begin
                        check("rand_block", o_block, exp_q.pop_front());
                        outstanding--;
                    end
                end
                if (i_byte_valid) begin
                    i_byte_valid = 1'b0;
                end else if (gap > 0) begin
                    gap--;
                end else if (sent < 128 && outstanding < 2) begin
                    b = 8'($urandom);
                    i_byte = b;
                    i_byte_valid = 1'b1;
                    cur[nb*8 +: 8] = b;
                    nb++;
                    sent++;
                    if (nb == 16) begin
                        exp_q.push_back(cur);
                        nb = 0;
                        outstanding++;
                    end
                    gap = $urandom_range(0, 4);
                end
            end
            total++;
            if (sent != 128 || exp_q.size() != 0) begin
                bad++;
                $display("FAIL rand_bound: sent %0d left %0d after %0d cycles", sent,
                         exp_q.size(), cyc);
            end
            check("rand_overrun", o_overrun, 0);
            check("rand_timeout", timeout_seen, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
